// File: rtl/pu_bank.sv
// Bank of parallel MAC neurons: streams a layer, then scales, activates
// and saturates every PU result, pulsing ready_8_pu when all are valid.
module pu_bank #(
  parameter int N_PU   = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int SHIFT  = 7,
  parameter int LEN_W  = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_pu,
  input  logic [LEN_W-1:0]         layer_len,
  input  logic                     relu_en,
  input  logic [N_PU*DATA_W-1:0]   bias_in,
  output logic                     rd_en,
  output logic [LEN_W-1:0]         rd_idx,
  input  logic [DATA_W-1:0]        x_in,
  input  logic [N_PU*DATA_W-1:0]   w_in,
  output logic [N_PU*DATA_W-1:0]   y_out,
  output logic                     busy,
  output logic                     ready_8_pu
);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ACT,
    DONE
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_t state, state_nx;

  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        j_q;
  logic                    relu_q;
  logic signed [ACC_W-1:0] acc_q [N_PU];

  logic signed [2*DATA_W-1:0] pw   [N_PU];
  logic signed [ACC_W-1:0]    prod [N_PU];
  logic signed [ACC_W-1:0]    sh   [N_PU];
  logic [DATA_W-1:0]          act  [N_PU];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    busy       = (state != IDLE);
    ready_8_pu = (state == DONE);
    rd_en      = 1'b0;
    rd_idx     = '0;
    case (state)
      IDLE: if (start_pu) state_nx = MAC;
      MAC: begin
        rd_en = (j_q < len_q);
        if (rd_en) rd_idx = j_q;
        if (j_q == len_q) state_nx = ACT;
      end
      ACT:     state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Product, scale, ReLU and clamp per PU.
  always_comb begin
    for (int i = 0; i < N_PU; i++) begin
      pw[i] = $signed(x_in) *
              $signed(w_in[i*DATA_W +: DATA_W]);
      prod[i] = ACC_W'(pw[i]);
      sh[i] = acc_q[i] >>> SHIFT;
      if (relu_q && sh[i] < 0) sh[i] = '0;
      if (sh[i] > SAT_MAX)
        act[i] = SAT_MAX[DATA_W-1:0];
      else if (sh[i] < SAT_MIN)
        act[i] = SAT_MIN[DATA_W-1:0];
      else
        act[i] = sh[i][DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q  <= '0;
      j_q    <= '0;
      relu_q <= 1'b0;
      y_out  <= '0;
      for (int i = 0; i < N_PU; i++) acc_q[i] <= '0;
    end else begin
      case (state)
        IDLE: if (start_pu) begin
          len_q  <= layer_len;
          relu_q <= relu_en;
          j_q    <= '0;
          for (int i = 0; i < N_PU; i++)
            acc_q[i] <= ACC_W'($signed(
              bias_in[i*DATA_W +: DATA_W])) <<< SHIFT;
        end
        MAC: begin
          j_q <= j_q + LEN_W'(1);
          // j=0 only issues the first read; data arrives from j=1 on.
          if (j_q != '0)
            for (int i = 0; i < N_PU; i++)
              acc_q[i] <= acc_q[i] + prod[i];
        end
        ACT:
          for (int i = 0; i < N_PU; i++)
            y_out[i*DATA_W +: DATA_W] <= act[i];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_bank.sv
// Bench for pu_bank: synchronous memory model, per-pass arithmetic model
// and a per-cycle compare process, plus literal spot checks.
module tb_pu_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_pu;
  logic [6:0]  layer_len;
  logic        relu_en;
  logic [63:0] bias_in;
  logic        rd_en;
  logic [6:0]  rd_idx;
  logic [7:0]  x_in;
  logic [63:0] w_in;
  logic [63:0] y_out;
  logic        busy;
  logic        ready_8_pu;

  pu_bank dut (
    .clk        (clk),
    .rst        (rst),
    .start_pu   (start_pu),
    .layer_len  (layer_len),
    .relu_en    (relu_en),
    .bias_in    (bias_in),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .x_in       (x_in),
    .w_in       (w_in),
    .y_out      (y_out),
    .busy       (busy),
    .ready_8_pu (ready_8_pu)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          s;
    int          l;
    logic [63:0] y;
  } pass_t;

  logic [7:0]  xm [128];
  logic [63:0] wm [128];

  pass_t       q [$];
  int          cyc = 0;
  int          idle_at = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_ready = 0;
  int          last_ready = -1;
  bit          chk_en = 0;
  logic [63:0] y_hold = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (rd_en) begin
      x_in <= xm[rd_idx];
      w_in <= wm[rd_idx];
    end

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  function automatic logic [63:0] model_y(input int l, input bit relu,
                                          input logic [63:0] bias);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      int s;
      int t;
      s = 128 * int'($signed(bias[i*8 +: 8]));
      for (int k = 0; k < l; k++)
        s += int'($signed(xm[k])) * int'($signed(wm[k][i*8 +: 8]));
      t = s / 128;
      if (s < 0 && (s % 128) != 0) t = t - 1;
      if (relu && t < 0) t = 0;
      if (t > 127) t = 127;
      if (t < -128) t = -128;
      r[i*8 +: 8] = t[7:0];
    end
    return r;
  endfunction

  always @(negedge clk)
    if (chk_en) begin
      int c;
      bit e_rd, e_busy, e_rdy;
      int e_idx;
      c = cyc;
      while (q.size() > 0 && c > q[0].s + q[0].l + 3)
        void'(q.pop_front());
      e_rd = 0; e_busy = 0; e_rdy = 0; e_idx = 0;
      if (q.size() > 0) begin
        int s, l;
        s = q[0].s;
        l = q[0].l;
        e_busy = (c >= s + 1 && c <= s + l + 3);
        if (c >= s + 1 && c <= s + l) begin
          e_rd = 1;
          e_idx = c - s - 1;
        end
        if (c == s + l + 3) begin
          e_rdy = 1;
          y_hold = q[0].y;
        end
      end
      chk("ready_8_pu", 64'(ready_8_pu), 64'(e_rdy));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("rd_en", 64'(rd_en), 64'(e_rd));
      if (e_rd) chk("rd_idx", 64'(rd_idx), 64'(e_idx));
      chk("y_out", y_out, y_hold);
      if (ready_8_pu) begin
        n_ready++;
        last_ready = c;
      end
    end

  task automatic wait_idle();
    while (cyc < idle_at) @(negedge clk);
  endtask

  task automatic start_pass(input int l, input bit relu,
                            input logic [63:0] bias, output int s);
    pass_t p;
    wait_idle();
    layer_len = 7'(l);
    relu_en   = relu;
    bias_in   = bias;
    start_pu  = 1'b1;
    s = cyc;
    p.s = s;
    p.l = l;
    p.y = model_y(l, relu, bias);
    q.push_back(p);
    idle_at = s + l + 4;
    @(negedge clk);
    start_pu  = 1'b0;
    layer_len = 7'($urandom);
    relu_en   = ~relu;
    bias_in   = {$urandom, $urandom};
  endtask

  task automatic fill_rand(input int l);
    for (int k = 0; k < l; k++) begin
      xm[k] = 8'($urandom);
      wm[k] = {$urandom, $urandom};
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, n_cmp %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int s, r0;
    rst = 1'b1;
    start_pu = 1'b0;
    layer_len = '0;
    relu_en = 1'b0;
    bias_in = '0;
    x_in = '0;
    w_in = '0;
    for (int k = 0; k < 128; k++) begin
      xm[k] = '0;
      wm[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ready_8_pu), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_rd_idx", 64'(rd_idx), 64'd0);
    chk("rst_y_out", y_out, 64'd0);
    rst = 1'b0;
    idle_at = cyc;
    chk_en = 1;

    // x=64,64; PU0 w=+64, PU1 w=-64; ReLU then linear
    fill_rand(2);
    for (int k = 0; k < 2; k++) begin
      xm[k] = 8'd64;
      wm[k][7:0] = 8'h40;
      wm[k][15:8] = 8'hC0;
    end
    start_pass(2, 1'b1, 64'd0, s);
    wait_idle();
    chk("t2_y0", 64'(y_out[7:0]), 64'h40);
    chk("t3_y1_relu", 64'(y_out[15:8]), 64'h00);
    chk("t2_ready_lat", 64'(last_ready - s), 64'd5);
    start_pass(2, 1'b0, 64'd0, s);
    wait_idle();
    chk("t3_y0_lin", 64'(y_out[7:0]), 64'h40);
    chk("t3_y1_lin", 64'(y_out[15:8]), 64'hC0);

    // saturation both ways
    for (int k = 0; k < 2; k++) begin
      xm[k] = 8'd127;
      wm[k][7:0] = 8'h7F;
      wm[k][15:8] = 8'h80;
    end
    start_pass(2, 1'b0, 64'd0, s);
    wait_idle();
    chk("t4_sat_hi", 64'(y_out[7:0]), 64'h7F);
    chk("t4_sat_lo", 64'(y_out[15:8]), 64'h80);

    // empty layer: result is the activated bias
    start_pass(0, 1'b0, {8{8'd5}}, s);
    wait_idle();
    chk("t6_y", y_out, {8{8'd5}});
    chk("t6_ready_lat", 64'(last_ready - s), 64'd3);

    // random mid-size layers, both activations
    fill_rand(9);
    start_pass(9, 1'b1, {$urandom, $urandom}, s);
    start_pass(9, 1'b0, {$urandom, $urandom}, s);
    wait_idle();

    // six back-to-back passes with start held high
    fill_rand(62);
    wait_idle();
    r0 = n_ready;
    layer_len = 7'd62;
    relu_en = 1'b0;
    bias_in = {$urandom, $urandom};
    start_pu = 1'b1;
    s = cyc;
    for (int k = 0; k < 6; k++) begin
      pass_t p;
      p.s = s + 66 * k;
      p.l = 62;
      p.y = model_y(62, 1'b0, bias_in);
      q.push_back(p);
    end
    idle_at = s + 6 * 66;
    while (cyc < s + 5 * 66 + 1) @(negedge clk);
    start_pu = 1'b0;
    wait_idle();
    chk("t5_pulses", 64'(n_ready - r0), 64'd6);
    chk("t5_last_ready", 64'(last_ready - s), 64'(5 * 66 + 65));

    // reset in the middle of a long MAC phase
    fill_rand(62);
    start_pass(62, 1'b1, {$urandom, $urandom}, s);
    repeat (20) @(negedge clk);
    chk_en = 0;
    rst = 1'b1;
    @(negedge clk);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_ready", 64'(ready_8_pu), 64'd0);
    chk("t1_y_out", y_out, 64'd0);
    chk("t1_rd_en", 64'(rd_en), 64'd0);
    rst = 1'b0;
    q.delete();
    y_hold = '0;
    idle_at = cyc;
    r0 = n_ready;
    chk_en = 1;
    repeat (100) @(negedge clk);
    chk("t1_no_pulse", 64'(n_ready - r0), 64'd0);

    // recovery after reset
    fill_rand(3);
    start_pass(3, 1'b1, {$urandom, $urandom}, s);
    wait_idle();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
